uart_frame_ctrl: RTL and testbench

Frame-level controller behind the 8N1 UART receiver. It consumes the receiver's byte/done outputs, hunts for a sync byte, sequences length, payload and checksum fields, and writes the payload into an external byte buffer. It reports a validated frame or a classified error. It sits between the UART RX core and the command decoder on the 80 MHz domain.

---
 rtl/uart_frame_pkg.sv | 26 ++
 rtl/uart_frame_ctrl_strobe.sv | 19 +
 rtl/uart_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } frame_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

  function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_strobe.sv
// Rising-edge detector on the UART RX done level; delay register resets high.
module uart_byte_strobe (
  input  logic clkIN,
  input  logic nResetIN,
  input  logic rxDoneIN,
  output logic byteStbOUT
);

  logic done_dly_q;

  // A done level already high at reset release must not look like a new byte.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) done_dly_q <= 1'b1;
    else           done_dly_q <= rxDoneIN;
  end

  assign byteStbOUT = rxDoneIN & ~done_dly_q;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer: SYNC, LEN, payload, CSUM with inter-byte timeout.
// Optional statistics counters are enabled by defining UART_FRAME_STATS_EN.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned TIMEOUT_CLKS = 1600,
  parameter int unsigned ADDR_W       = 6
) (
  input  logic              clkIN,
  input  logic              nResetIN,
  input  logic [7:0]        rxDataIN,
  input  logic              rxDoneIN,
  output logic              wrEnOUT,
  output logic [ADDR_W-1:0] wrAddrOUT,
  output logic [7:0]        wrDataOUT,
  output logic              frameValidOUT,
  output logic [7:0]        frameLenOUT,
  output logic              frameErrOUT,
  output logic [1:0]        errCodeOUT,
  output logic              busyOUT
`ifdef UART_FRAME_STATS_EN
  ,
  input  logic              statClrIN,
  output logic [15:0]       goodCntOUT,
  output logic [15:0]       errCntOUT
`endif
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CLKS - 2);

  logic byte_stb;

  uart_byte_strobe u_strobe (
    .clkIN      (clkIN),
    .nResetIN   (nResetIN),
    .rxDoneIN   (rxDoneIN),
    .byteStbOUT (byte_stb)
  );

  frame_state_e     state_q, state_d;
  logic [7:0]       len_q, len_d, acc_q, acc_d, idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             wr_en_q, wr_en_d, valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d, flen_q, flen_d;
  logic [1:0]       code_q, code_d;
  logic             len_good, csum_good, tmo_hit, len_err, csum_err;

  assign len_good  = len_ok(rxDataIN, MAX_LEN);
  assign csum_good = (rxDataIN == acc_q);
  // Timeout fires as the counter steps onto TIMEOUT_CLKS-1; a same-cycle byte wins.
  assign tmo_hit   = (state_q != ST_HUNT) && !byte_stb && (tmo_q == TMO_FIRE);
  assign len_err   = byte_stb && (state_q == ST_LEN) && !len_good;
  assign csum_err  = byte_stb && (state_q == ST_CSUM) && !csum_good;

  // State, datapath and registered outputs.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q   <= ST_HUNT;
      len_q     <= 8'd0;
      acc_q     <= 8'd0;
      idx_q     <= 8'd0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      valid_q   <= 1'b0;
      flen_q    <= 8'd0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      valid_q   <= valid_d;
      flen_q    <= flen_d;
      err_q     <= err_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and field sequencing; SYNC inside a frame is ordinary data.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    tmo_d   = (byte_stb || (state_q == ST_HUNT)) ? '0 : tmo_q + TMO_W'(1);
    if (tmo_hit) begin
      state_d = ST_HUNT;
    end else if (byte_stb) begin
      case (state_q)
        ST_HUNT: begin
          if (rxDataIN == SYNC_BYTE) state_d = ST_LEN;
          else                       state_d = ST_HUNT;
        end
        ST_LEN: begin
          if (len_good) begin
            len_d   = rxDataIN;
            acc_d   = rxDataIN;
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          acc_d = acc_q + rxDataIN;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = ST_CSUM;
          else                       state_d = ST_PAYLOAD;
        end
        ST_CSUM: state_d = ST_HUNT;
        default: state_d = ST_HUNT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode; the three pulses come from disjoint conditions.
  always_comb begin
    wr_en_d   = byte_stb && (state_q == ST_PAYLOAD);
    valid_d   = byte_stb && (state_q == ST_CSUM) && csum_good;
    err_d     = tmo_hit || len_err || csum_err;
    busy_d    = (state_d != ST_HUNT);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    flen_d    = flen_q;
    code_d    = code_q;
    if (wr_en_d) begin
      wr_addr_d = ADDR_W'(idx_q);
      wr_data_d = rxDataIN;
    end else begin
      wr_data_d = wr_data_q;
    end
    if (valid_d) flen_d = len_q;
    else         flen_d = flen_q;
    if (tmo_hit)       code_d = ERR_TIMEOUT;
    else if (len_err)  code_d = ERR_LEN;
    else if (csum_err) code_d = ERR_CSUM;
    else               code_d = code_q;
  end

  assign wrEnOUT       = wr_en_q;
  assign wrAddrOUT     = wr_addr_q;
  assign wrDataOUT     = wr_data_q;
  assign frameValidOUT = valid_q;
  assign frameLenOUT   = flen_q;
  assign frameErrOUT   = err_q;
  assign errCodeOUT    = code_q;
  assign busyOUT       = busy_q;

`ifdef UART_FRAME_STATS_EN
  logic [15:0] good_cnt_q, err_cnt_q;

  // Saturating frame counters; a clear request beats a coincident increment.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      good_cnt_q <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else if (statClrIN) begin
      good_cnt_q <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      if (valid_q) good_cnt_q <= sat_inc16(good_cnt_q);
      if (err_q)   err_cnt_q  <= sat_inc16(err_cnt_q);
    end
  end

  assign goodCntOUT = good_cnt_q;
  assign errCntOUT  = err_cnt_q;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed cases plus random frames
// compared against a frame-level reference model.
module tb_uart_frame_ctrl;

  localparam int MAX_LEN = 64;
  localparam int TC      = 1600;

  logic       clkIN = 1'b0;
  logic       nResetIN = 1'b0;
  logic       rxDoneIN = 1'b0;
  logic [7:0] rxDataIN = 8'd0;
  logic       wrEnOUT, frameValidOUT, frameErrOUT, busyOUT;
  logic [5:0] wrAddrOUT;
  logic [7:0] wrDataOUT, frameLenOUT;
  logic [1:0] errCodeOUT;
`ifdef UART_FRAME_STATS_EN
  logic        statClrIN = 1'b0;
  logic [15:0] goodCntOUT, errCntOUT;
`endif

  uart_frame_ctrl dut (
    .clkIN(clkIN), .nResetIN(nResetIN), .rxDataIN(rxDataIN), .rxDoneIN(rxDoneIN),
    .wrEnOUT(wrEnOUT), .wrAddrOUT(wrAddrOUT), .wrDataOUT(wrDataOUT),
    .frameValidOUT(frameValidOUT), .frameLenOUT(frameLenOUT),
    .frameErrOUT(frameErrOUT), .errCodeOUT(errCodeOUT), .busyOUT(busyOUT)
`ifdef UART_FRAME_STATS_EN
    , .statClrIN(statClrIN), .goodCntOUT(goodCntOUT), .errCntOUT(errCntOUT)
`endif
  );

  always #5 clkIN = ~clkIN;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cyc = 0;
  int err_cyc = 0;
  int obs_wr[$], obs_val[$], obs_err[$];
  int exp_wr[$], exp_val[$], exp_err[$];
  logic [7:0] stim_q[$];

  always @(posedge clkIN) cyc <= cyc + 1;

  // Record every output event; pulses must never overlap.
  always @(negedge clkIN) begin
    if (wrEnOUT) begin
      obs_wr.push_back(int'(wrAddrOUT) * 256 + int'(wrDataOUT));
      wr_cyc = cyc;
    end
    if (frameValidOUT) obs_val.push_back(int'(frameLenOUT));
    if (frameErrOUT) begin
      obs_err.push_back(int'(errCodeOUT));
      err_cyc = cyc;
    end
    if (nResetIN) begin
      total++;
      assert ((32'(wrEnOUT) + 32'(frameValidOUT) + 32'(frameErrOUT)) <= 32'd1) else begin
        bad++;
        $error("FAIL excl observed=%0b%0b%0b expected at most one pulse", wrEnOUT, frameValidOUT, frameErrOUT);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkIN);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxDataIN = b;
    rxDoneIN = 1'b1;
    tick(3);
    rxDoneIN = 1'b0;
    tick(3);
    stim_q.push_back(b);
  endtask

  // Send a byte that must be rejected as a bad length; checks the very next cycle.
  task automatic send_badlen(input logic [7:0] b);
    rxDataIN = b;
    rxDoneIN = 1'b1;
    tick(1);
    chk("badlen_err", frameErrOUT, 1);
    chk("badlen_code", errCodeOUT, 1);
    chk("badlen_busy", busyOUT, 0);
    tick(2);
    rxDoneIN = 1'b0;
    tick(3);
    stim_q.push_back(b);
  endtask

  // Reference: scan the byte stream by frame format with plain arithmetic.
  task automatic run_model();
    int i = 0;
    int n;
    int len;
    int sum;
    n = stim_q.size();
    while (i < n) begin
      if (stim_q[i] != 8'h7E) begin
        i++;
        continue;
      end
      if (i + 1 >= n) break;
      len = int'(stim_q[i+1]);
      if (len == 0 || len > MAX_LEN) begin
        exp_err.push_back(1);
        i += 2;
        continue;
      end
      if (i + 2 + len >= n) break;
      sum = len;
      for (int k = 0; k < len; k++) begin
        exp_wr.push_back(k * 256 + int'(stim_q[i+2+k]));
        sum += int'(stim_q[i+2+k]);
      end
      if ((sum % 256) == int'(stim_q[i+2+len])) exp_val.push_back(len);
      else                                      exp_err.push_back(3);
      i += len + 3;
    end
    stim_q.delete();
  endtask

  task automatic clear_all();
    obs_wr.delete(); obs_val.delete(); obs_err.delete();
    exp_wr.delete(); exp_val.delete(); exp_err.delete();
    stim_q.delete();
  endtask

  task automatic compare(input string tag);
    run_model();
    tick(2);
    chk({tag, ":nwr"}, obs_wr.size(), exp_wr.size());
    for (int k = 0; k < obs_wr.size() && k < exp_wr.size(); k++) chk({tag, ":wr"}, obs_wr[k], exp_wr[k]);
    chk({tag, ":nval"}, obs_val.size(), exp_val.size());
    for (int k = 0; k < obs_val.size() && k < exp_val.size(); k++) chk({tag, ":val"}, obs_val[k], exp_val[k]);
    chk({tag, ":nerr"}, obs_err.size(), exp_err.size());
    for (int k = 0; k < obs_err.size() && k < exp_err.size(); k++) chk({tag, ":err"}, obs_err[k], exp_err[k]);
    chk({tag, ":busy"}, busyOUT, 0);
    clear_all();
  endtask

  task automatic send_frame(input int len, input bit bad_cs);
    int sum;
    logic [7:0] b;
    send_byte(8'h7E);
    send_byte(8'(len));
    sum = len;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      sum += int'(b);
      send_byte(b);
    end
    if (bad_cs) sum += 1 + $urandom_range(0, 254);
    send_byte(8'(sum));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":wren"}, wrEnOUT, 0);
    chk({tag, ":addr"}, wrAddrOUT, 0);
    chk({tag, ":data"}, wrDataOUT, 0);
    chk({tag, ":valid"}, frameValidOUT, 0);
    chk({tag, ":flen"}, frameLenOUT, 0);
    chk({tag, ":err"}, frameErrOUT, 0);
    chk({tag, ":code"}, errCodeOUT, 0);
    chk({tag, ":busy"}, busyOUT, 0);
`ifdef UART_FRAME_STATS_EN
    chk({tag, ":good"}, goodCntOUT, 0);
    chk({tag, ":errc"}, errCntOUT, 0);
`endif
  endtask

  initial begin
    int blen;
    tick(2);
    chk_all_zero("reset");

    // Done already high when reset releases: no strobe.
    rxDataIN = 8'h7E;
    rxDoneIN = 1'b1;
    nResetIN = 1'b1;
    tick(5);
    chk("done_at_release_busy", busyOUT, 0);
    rxDoneIN = 1'b0;
    tick(3);
    compare("done_at_release");

    // Good frame.
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    compare("good3");
    chk("good3_flen", frameLenOUT, 3);
    chk("good3_code", errCodeOUT, 0);

    // Checksum mismatch.
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
    send_byte(8'h55); send_byte(8'h00);
    compare("badcs");
    chk("badcs_code", errCodeOUT, 3);
    chk("badcs_flen", frameLenOUT, 3);

    // Bad lengths: zero and MAX_LEN+1.
    send_byte(8'h7E); send_badlen(8'h00);
    send_byte(8'h7E); send_badlen(8'h41);
    compare("badlen");

    // Noise in HUNT.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h7D);
    compare("noise");

    // Inter-byte timeout after a partial payload.
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
    for (int c = 0; c < TC + 50 && obs_err.size() == 0; c++) tick(1);
    chk("tmo_nerr", obs_err.size(), 1);
    if (obs_err.size() > 0) chk("tmo_code", obs_err[0], 2);
    chk("tmo_latency", err_cyc - wr_cyc, TC - 1);
    chk("tmo_nwr", obs_wr.size(), 1);
    if (obs_wr.size() > 0) chk("tmo_wr", obs_wr[0], 32'h00AA);
    tick(1);
    chk("tmo_busy", busyOUT, 0);
    clear_all();
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    compare("after_tmo");

    // Done held high for 1000 cycles gives one strobe only.
    rxDataIN = 8'h7E;
    rxDoneIN = 1'b1;
    tick(1000);
    chk("held_busy", busyOUT, 1);
    chk("held_nerr", obs_err.size(), 0);
    rxDoneIN = 1'b0;
    tick(3);
    stim_q.push_back(8'h7E);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    compare("held");

    // Random frames with noise, bad lengths and bad checksums.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        send_byte((($urandom_range(0, 255) == 32'h7E) ? 8'h00 : 8'($urandom_range(0, 255))));
      end
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'h7E);
        blen = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
        send_byte(8'(blen));
      end else begin
        blen = (f == 0) ? MAX_LEN : (f == 1) ? 1 : int'($urandom_range(1, MAX_LEN));
        send_frame(blen, $urandom_range(0, 3) == 0);
      end
      compare("rand");
    end

    // Asynchronous reset in the middle of a payload.
    send_byte(8'h7E); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    #2 nResetIN = 1'b0;
    #1 chk_all_zero("midreset");
    tick(2);
    nResetIN = 1'b1;
    tick(2);
    clear_all();
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h10); send_byte(8'h11);
    compare("post_reset");
    chk("post_reset_flen", frameLenOUT, 1);
`ifdef UART_FRAME_STATS_EN
    chk("stats_good", goodCntOUT, 1);
    chk("stats_err", errCntOUT, 0);
    statClrIN = 1'b1;
    tick(1);
    statClrIN = 1'b0;
    chk("stats_clr", goodCntOUT, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
